// File: rtl/fft64_sched.sv
// fft64_sched: two-pass 64-point FFT sequencer around the 8-point core.
// Pass 0 issues stride-8 groups, pass 1 contiguous groups; pass 1 cannot
// start reading until the eighth pass-0 result has been written back.
// Optional macro FFT64_SCHED_STALL_EN adds a `stall` input gating issue.
module fft64_sched #(
  parameter int RD_LAT   = 1,
  parameter int CORE_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
`ifdef FFT64_SCHED_STALL_EN
  input  logic       stall,
`endif
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       rd_en,
  output logic [2:0] rd_grp,
  output logic       core_vld_in,
  input  logic       core_vld_out,
  output logic       wr_en,
  output logic [2:0] wr_grp
);

  // Elaboration-time sanity check on the latency parameters.
  if (RD_LAT < 1 || CORE_LAT < 1) begin : g_param_chk
    $error("fft64_sched: RD_LAT and CORE_LAT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic              pass_q, pass_d;
  logic [2:0]        rd_cnt_q, rd_cnt_d;
  logic [2:0]        wr_cnt_q, wr_cnt_d;
  logic              rd_en_q, rd_en_d;
  logic [2:0]        rd_grp_q, rd_grp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;

  logic       stall_w;
  logic       clr;
  logic       issue;
  logic       wr_last;
  logic [2:0] rd_base;

`ifdef FFT64_SCHED_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  // Write-back is combinational so the group index lines up with core output.
  assign wr_en   = core_vld_out & busy_q;
  assign wr_grp  = wr_cnt_q;
  assign wr_last = wr_en & (wr_cnt_q == 3'd7);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, pass and counters; the issue decision is taken on the edge
  // entering ISSUE so the first read appears the cycle right after start.
  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    clr      = 1'b0;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    case (state_q)
      IDLE:  if (start) begin state_d = ISSUE; pass_d = 1'b0; clr = 1'b1; end
      ISSUE: ;
      DRAIN: if (wr_last) begin
               if (!pass_q) begin state_d = ISSUE; pass_d = 1'b1; clr = 1'b1; end
               else         state_d = DONE;
             end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rd_base = clr ? 3'd0 : rd_cnt_q;
    if (clr)        wr_cnt_d = 3'd0;
    else if (wr_en) wr_cnt_d = wr_cnt_q + 3'd1;
    issue = (state_d == ISSUE) & ~stall_w;
    if (clr) rd_cnt_d = 3'd0;
    if (issue) begin
      rd_cnt_d = rd_base + 3'd1;
      if (rd_base == 3'd7) state_d = DRAIN;
    end
  end

  // Registered outputs derived from the upcoming state and issue decision.
  always_comb begin
    busy_d        = (state_d == ISSUE) || (state_d == DRAIN);
    done_d        = (state_d == DONE);
    rd_en_d       = issue;
    rd_grp_d      = issue ? rd_base : rd_grp_q;
    vld_pipe_d    = vld_pipe_q;
    vld_pipe_d[0] = rd_en_q;
    for (int i = 1; i < RD_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
  end

  // Datapath registers; reset aborts a transform without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q     <= 1'b0;
      rd_cnt_q   <= 3'd0;
      wr_cnt_q   <= 3'd0;
      rd_en_q    <= 1'b0;
      rd_grp_q   <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      pass_q     <= pass_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_en_q    <= rd_en_d;
      rd_grp_q   <= rd_grp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign rd_en       = rd_en_q;
  assign rd_grp      = rd_grp_q;
  assign core_vld_in = vld_pipe_q[RD_LAT-1];

endmodule

// File: tb/tb_fft64_sched.sv
// tb_fft64_sched: directed bench for fft64_sched with a 2-cycle core model.
// Cycle k is the interval after clock edge k-1; start is sampled at edge 0.
module tb_fft64_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, start3 = 1'b0, stall = 1'b0, spur = 1'b0;

  logic busy, done, pass, rd_en, cvi, cvo, wr_en;
  logic [2:0] rd_grp, wr_grp;
  logic busy3, done3, pass3, rd_en3, cvi3, cvo3, wr_en3;
  logic [2:0] rd_grp3, wr_grp3;
  logic [1:0] cm, cm3;

  always #5 clk = ~clk;

  fft64_sched #(.RD_LAT(1), .CORE_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef FFT64_SCHED_STALL_EN
    .stall(stall),
`endif
    .busy(busy), .done(done), .pass(pass), .rd_en(rd_en), .rd_grp(rd_grp),
    .core_vld_in(cvi), .core_vld_out(cvo), .wr_en(wr_en), .wr_grp(wr_grp));

  fft64_sched #(.RD_LAT(3), .CORE_LAT(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
`ifdef FFT64_SCHED_STALL_EN
    .stall(1'b0),
`endif
    .busy(busy3), .done(done3), .pass(pass3), .rd_en(rd_en3), .rd_grp(rd_grp3),
    .core_vld_in(cvi3), .core_vld_out(cvo3), .wr_en(wr_en3), .wr_grp(wr_grp3));

  // Core models: pure 2-cycle valid delay; spur injects a stray vld_out.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin cm <= 2'b0; cm3 <= 2'b0; end
    else begin cm <= {cm[0], cvi}; cm3 <= {cm3[0], cvi3}; end
  end
  assign cvo  = cm[1] | spur;
  assign cvo3 = cm3[1];

  typedef struct packed {
    logic rd_en; logic [2:0] rd_grp; logic pass; logic cvi;
    logic wr_en; logic [2:0] wr_grp; logic busy; logic done;
  } snap_t;
  typedef struct {int cyc; snap_t e;} vec_t;

  snap_t snap [0:63];
  vec_t  tbl  [14];
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int c, bit r, int rg, bit p, bit cv, bit w, int wg, bit b, bit d);
    vec_t v;
    v.cyc = c;
    v.e = {r, 3'(rg), p, cv, w, 3'(wg), b, d};
    return v;
  endfunction

  task automatic tick(input bit use3, input int k);
    @(negedge clk);
    if (use3) snap[k] = {rd_en3, rd_grp3, pass3, cvi3, wr_en3, wr_grp3, busy3, done3};
    else      snap[k] = {rd_en, rd_grp, pass, cvi, wr_en, wr_grp, busy, done};
  endtask

  // Called at a negedge ("cycle 0"); start is sampled at the next edge.
  task automatic run_xact(input int ncyc, input int sa, input int sb, input int sc,
                          input int sd, input int stl_lo, input int stl_hi, input bit use3);
    if (use3) start3 = 1'b1; else start = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      tick(use3, k);
      if (use3) start3 = (k == sa || k == sb || k == sc || k == sd);
      else      start  = (k == sa || k == sb || k == sc || k == sd);
      stall = (k >= stl_lo && k <= stl_hi);
    end
    start = 1'b0; start3 = 1'b0; stall = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; spur = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 14; i++) begin
      snap_t s, e;
      int c;
      c = tbl[i].cyc; s = snap[c]; e = tbl[i].e;
      chk($sformatf("%s c%0d rd_en", tag, c), s.rd_en, e.rd_en);
      if (e.rd_en) chk($sformatf("%s c%0d rd_grp", tag, c), s.rd_grp, e.rd_grp);
      if (e.busy)  chk($sformatf("%s c%0d pass", tag, c), s.pass, e.pass);
      chk($sformatf("%s c%0d core_vld_in", tag, c), s.cvi, e.cvi);
      chk($sformatf("%s c%0d wr_en", tag, c), s.wr_en, e.wr_en);
      chk($sformatf("%s c%0d wr_grp", tag, c), s.wr_grp, e.wr_grp);
      chk($sformatf("%s c%0d busy", tag, c), s.busy, e.busy);
      chk($sformatf("%s c%0d done", tag, c), s.done, e.done);
    end
  endtask

  // Whole-transform properties over cycles 1..lim of the recorded trace.
  task automatic check_xact(input string tag, input int lim, input int done_c,
                            input int busy_n, input int lat, output int p1first);
    int nr, nw, rd_bad, wr_bad, ndone, dcyc, nbusy, lag_bad, w8;
    nr = 0; nw = 0; rd_bad = 0; wr_bad = 0; ndone = 0; dcyc = -1;
    nbusy = 0; lag_bad = 0; w8 = -1; p1first = -1;
    for (int k = 1; k <= lim; k++) begin
      snap_t s;
      s = snap[k];
      if (s.rd_en) begin
        if (s.rd_grp != 3'(nr % 8) || s.pass != (nr / 8)) rd_bad++;
        if (nr == 8) p1first = k;
        nr++;
      end
      if (s.wr_en) begin
        if (s.wr_grp != 3'(nw % 8) || s.pass != (nw / 8)) wr_bad++;
        if (nw == 7) w8 = k;
        nw++;
      end
      if (s.done) begin ndone++; dcyc = k; end
      if (s.busy) nbusy++;
      if (k > lat) begin if (s.cvi != snap[k-lat].rd_en) lag_bad++; end
      else if (s.cvi) lag_bad++;
    end
    chk({tag, " reads"}, nr, 16);
    chk({tag, " read order"}, rd_bad, 0);
    chk({tag, " writes"}, nw, 16);
    chk({tag, " write order"}, wr_bad, 0);
    chk({tag, " done pulses"}, ndone, 1);
    chk({tag, " done cycle"}, dcyc, done_c);
    chk({tag, " busy cycles"}, nbusy, busy_n);
    chk({tag, " vld_in lag"}, lag_bad, 0);
    chk({tag, " pass1 after 8th write"}, int'(p1first > w8), 1);
  endtask

  initial begin
    int p;
    tbl[0]  = mk(1,  1, 0, 0, 0, 0, 0, 1, 0);
    tbl[1]  = mk(2,  1, 1, 0, 1, 0, 0, 1, 0);
    tbl[2]  = mk(4,  1, 3, 0, 1, 1, 0, 1, 0);
    tbl[3]  = mk(8,  1, 7, 0, 1, 1, 4, 1, 0);
    tbl[4]  = mk(9,  0, 0, 0, 1, 1, 5, 1, 0);
    tbl[5]  = mk(10, 0, 0, 0, 0, 1, 6, 1, 0);
    tbl[6]  = mk(11, 0, 0, 0, 0, 1, 7, 1, 0);
    tbl[7]  = mk(12, 1, 0, 1, 0, 0, 0, 1, 0);
    tbl[8]  = mk(13, 1, 1, 1, 1, 0, 0, 1, 0);
    tbl[9]  = mk(15, 1, 3, 1, 1, 1, 0, 1, 0);
    tbl[10] = mk(19, 1, 7, 1, 1, 1, 4, 1, 0);
    tbl[11] = mk(22, 0, 0, 1, 0, 1, 7, 1, 0);
    tbl[12] = mk(23, 0, 0, 1, 0, 0, 0, 0, 1);
    tbl[13] = mk(24, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset outputs", int'({busy, done, pass, rd_en, rd_grp, cvi, wr_en, wr_grp}), 0);
    chk("reset outputs lat3", int'({busy3, done3, pass3, rd_en3, rd_grp3, cvi3, wr_en3, wr_grp3}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Baseline transform.
    run_xact(26, 0, 0, 0, 0, 0, -1, 1'b0);
    check_table("base");
    check_xact("base", 26, 23, 22, 1, p);
    chk("base pass1 first read", p, 12);
    do_reset();

    // Starts during the run and in the done cycle are ignored; next one is taken.
    run_xact(25, 5, 20, 23, 24, 0, -1, 1'b0);
    check_xact("start_ign", 24, 23, 22, 1, p);
    chk("restart rd_en c25", snap[25].rd_en, 1);
    chk("restart rd_grp c25", snap[25].rd_grp, 0);
    chk("restart pass c25", snap[25].pass, 0);
    do_reset();

`ifdef FFT64_SCHED_STALL_EN
    // Stall sampled on edges 2..4 holds off the issue slots of cycles 3..5.
    run_xact(30, 0, 0, 0, 0, 2, 4, 1'b0);
    for (int k = 1; k <= 11; k++)
      chk($sformatf("stall c%0d rd_en", k), snap[k].rd_en, int'(k <= 2 || k >= 6));
    check_xact("stall", 30, 26, 25, 1, p);
    chk("stall pass1 first read", p, 15);
    do_reset();
`endif

    // Stray core valid while idle: no write, no count.
    spur = 1'b1;
    #1;
    chk("spur wr_en", wr_en, 0);
    chk("spur wr_grp", wr_grp, 0);
    @(negedge clk);
    chk("spur wr_en 2", wr_en, 0);
    spur = 1'b0;
    @(negedge clk);
    chk("spur wr_grp after", wr_grp, 0);
    run_xact(26, 0, 0, 0, 0, 0, -1, 1'b0);
    check_table("post_spur");
    do_reset();

    // Async reset in cycle 14 clears everything before the next edge.
    run_xact(14, 0, 0, 0, 0, 0, -1, 1'b0);
    chk("pre-reset c14 busy", snap[14].busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midreset outputs", int'({busy, done, pass, rd_en, rd_grp, cvi, wr_en, wr_grp}), 0);
    repeat (2) @(negedge clk);
    chk("midreset held", int'({busy, done, pass, rd_en, rd_grp, cvi, wr_en, wr_grp}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_xact(26, 0, 0, 0, 0, 0, -1, 1'b0);
    check_table("rerun");
    check_xact("rerun", 26, 23, 22, 1, p);
    do_reset();

    // RD_LAT = 3 instance.
    run_xact(30, 0, 0, 0, 0, 0, -1, 1'b1);
    check_xact("lat3", 30, 27, 26, 3, p);
    chk("lat3 pass1 first read", p, 14);
    chk("lat3 c3 core_vld_in", snap[3].cvi, 0);
    chk("lat3 c4 core_vld_in", snap[4].cvi, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
